// File: rtl/ahb_sram_if.sv
// rtl/ahb_sram_if.sv - AHB-Lite slave bridge to a single-port synchronous 32-bit SRAM
//
// Purpose: turns AHB-Lite transfers into accesses on a single-port synchronous
// RAM with 1-cycle read latency and no byte enables. Sub-word writes are done as
// read-modify-write. Address bits above the RAM size are ignored (aliasing).
//
// Optional feature macro: AHB_SRAM_ERR_EN
//   When defined, oversized (hsize>2) or misaligned transfers get a two-cycle
//   ERROR response (states ERR1, ERR2) and touch no RAM location.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous active-high reset
//   hsel       in   1           slave select
//   haddr      in   32          byte address
//   htrans     in   2           transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     in   1           1 = write
//   hsize      in   3           transfer size
//   hwdata     in   32          write data (data phase)
//   hready     in   1           bus-wide ready
//   hreadyout  out  1           slave ready
//   hresp      out  1           0 = OKAY, 1 = ERROR
//   hrdata     out  32          read data (0 outside a read data phase)
//   ram_cen    out  1           RAM access enable
//   ram_wen    out  1           RAM write enable (1 = write)
//   ram_addr   out  ADDR_WIDTH  RAM word address
//   ram_data   out  32          RAM write data
//   ram_q      in   32          RAM read data, valid the cycle after a read

module ahb_sram_if #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  input  logic [31:0]           ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DLY,
    WR,
    RMW_RD,
    RMW_WR
`ifdef AHB_SRAM_ERR_EN
    ,
    ERR1,
    ERR2
`endif
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [3:0]            mask_q;

  logic                  accept;
  logic                  bad_xfer;
  logic                  port_busy;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [3:0]            lane_mask;
  logic [31:0]           merged;

  // Bits that carry no information for this slave: upper address bits alias,
  // htrans[0] only separates SEQ from NONSEQ, and the stored size is kept for
  // visibility only (the lane mask already encodes it).
  logic unused_bits;
  assign unused_bits = &{1'b0, haddr[31:ADDR_WIDTH+2], htrans[0], size_q, write_q};

  assign word_addr = haddr[ADDR_WIDTH+1:2];

  assign accept = hsel & hready & htrans[1] & hreadyout;

  // The RAM port is occupied by the write of the previous transfer.
  assign port_busy = (state == WR) || (state == RMW_WR);

`ifdef AHB_SRAM_ERR_EN
  assign bad_xfer = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
`else
  assign bad_xfer = 1'b0;
`endif

  always_comb begin
    case (hsize)
      3'd0:    lane_mask = 4'b0001 << haddr[1:0];
      3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Replace only the lanes being written; the rest come from the word just read.
  always_comb begin
    merged = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = mask_q[i] ? hwdata[8*i +: 8] : ram_q[8*i +: 8];
    end
  end

  // Stall states hold hreadyout low; everything else is decoded from state.
  always_comb begin
    hreadyout = 1'b1;
    case (state)
      RD_DLY, RMW_RD: hreadyout = 1'b0;
`ifdef AHB_SRAM_ERR_EN
      ERR1:           hreadyout = 1'b0;
`endif
      default:        hreadyout = 1'b1;
    endcase
  end

`ifdef AHB_SRAM_ERR_EN
  assign hresp = (state == ERR1) || (state == ERR2);
`else
  assign hresp = 1'b0;
`endif

  assign hrdata = (state == RD) ? ram_q : 32'h0;

  // RAM port: combinational from state and the current address phase.
  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = addr_q;
    ram_data = 32'h0;
    if (!rst) begin
      case (state)
        WR: begin
          ram_cen  = 1'b1;
          ram_wen  = 1'b1;
          ram_data = hwdata;
        end
        RMW_WR: begin
          ram_cen  = 1'b1;
          ram_wen  = 1'b1;
          ram_data = merged;
        end
        RD_DLY, RMW_RD: begin
          ram_cen = 1'b1;
        end
        default: ;
      endcase
      // A read issues straight away whenever the port is not writing.
      if (accept && !hwrite && !bad_xfer && !port_busy) begin
        ram_cen  = 1'b1;
        ram_addr = word_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      if (accept) begin
        addr_q  <= word_addr;
        write_q <= hwrite;
        size_q  <= hsize;
        mask_q  <= lane_mask;
      end
      case (state)
        RD_DLY: state <= RD;
        RMW_RD: state <= RMW_WR;
`ifdef AHB_SRAM_ERR_EN
        ERR1:   state <= ERR2;
`endif
        default: begin
          if (!accept)
            state <= IDLE;
          else if (bad_xfer) begin
`ifdef AHB_SRAM_ERR_EN
            state <= ERR1;
`else
            state <= IDLE;
`endif
          end else if (!hwrite)
            state <= port_busy ? RD_DLY : RD;
          else if (lane_mask == 4'b1111)
            state <= WR;
          else
            state <= RMW_RD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_if.sv
// tb/tb_ahb_sram_if.sv - directed self-checking bench for ahb_sram_if
module tb_ahb_sram_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        ram_cen;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic [31:0] ram_q;

  always #5 clk = ~clk;

  assign hready = hreadyout;

  ahb_sram_if #(.ADDR_WIDTH(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .ram_cen   (ram_cen),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_q     (ram_q)
  );

  // Single-port synchronous RAM, one cycle read latency.
  logic [31:0] mem [0:4095];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) begin
        mem[ram_addr] <= ram_data;
        wr_cnt        <= wr_cnt + 1;
      end else begin
        ram_q <= mem[ram_addr];
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pipelined transfer sequence: table of transfers, driven back to back.
  logic [31:0] sq_addr  [8];
  logic        sq_wr    [8];
  logic [2:0]  sq_size  [8];
  logic [31:0] sq_wdata [8];
  logic [31:0] rs_rdata [8];
  int          rs_waits [8];
  logic        rs_resp  [8];
  int          n_sq = 0;

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd);
    sq_addr[n_sq]  = a;
    sq_wr[n_sq]    = w;
    sq_size[n_sq]  = sz;
    sq_wdata[n_sq] = wd;
    rs_rdata[n_sq] = 32'hx;
    rs_waits[n_sq] = 0;
    rs_resp[n_sq]  = 1'bx;
    n_sq++;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_seq();
    int ap  = 0;
    int dp  = -1;
    int cyc = 0;
    while ((ap < n_sq || dp >= 0) && cyc < 100) begin
      if (ap < n_sq) begin
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = sq_addr[ap];
        hwrite = sq_wr[ap];
        hsize  = sq_size[ap];
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
      end
      hwdata = (dp >= 0) ? sq_wdata[dp] : 32'h0;
      @(negedge clk);
      if (hreadyout) begin
        if (dp >= 0) begin
          rs_rdata[dp] = hrdata;
          rs_resp[dp]  = hresp;
        end
        if (ap < n_sq) begin
          dp = ap;
          ap++;
        end else begin
          dp = -1;
        end
      end else if (dp >= 0) begin
        rs_waits[dp]++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("seq_completed", 32'(cyc < 100), 32'd1);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h0;
    n_sq   = 0;
  endtask

  initial begin
    rst    = 1'b1;
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hwdata = 32'h0;

    // Reset: a valid read presented during reset must not reach the RAM.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0;
    @(negedge clk);
    check("rst_ram_cen", 32'(ram_cen), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    rst  = 1'b0;
    @(negedge clk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    @(posedge clk); #1;

    // Word write then read of the same word: one wait state on the read.
    add(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    add(32'h10, 1'b0, 3'd2, 32'h0);
    run_seq();
    check("raw_wr_waits", 32'(rs_waits[0]), 32'd0);
    check("raw_wr_hrdata", rs_rdata[0], 32'h0);
    check("raw_rd_waits", 32'(rs_waits[1]), 32'd1);
    check("raw_rd_data", rs_rdata[1], 32'hDEADBEEF);
    check("raw_mem", mem[4], 32'hDEADBEEF);

    // Byte write into lane 3, read straight after, then halfword into lanes 1:0.
    add(32'h10, 1'b1, 3'd2, 32'h11223344);
    run_seq();
    add(32'h13, 1'b1, 3'd0, 32'hAA000000);
    add(32'h10, 1'b0, 3'd2, 32'h0);
    run_seq();
    check("byte_waits", 32'(rs_waits[0]), 32'd1);
    check("byte_mem", mem[4], 32'hAA223344);
    check("byte_rd_waits", 32'(rs_waits[1]), 32'd1);
    check("byte_rd_data", rs_rdata[1], 32'hAA223344);
    add(32'h10, 1'b1, 3'd1, 32'h00005566);
    run_seq();
    check("half_waits", 32'(rs_waits[0]), 32'd1);
    check("half_mem", mem[4], 32'hAA225566);

    // Four back-to-back writes, then four back-to-back reads.
    add(32'h0, 1'b1, 3'd2, 32'h01020304);
    add(32'h4, 1'b1, 3'd2, 32'h05060708);
    add(32'h8, 1'b1, 3'd2, 32'h090A0B0C);
    add(32'hC, 1'b1, 3'd2, 32'h0D0E0F10);
    run_seq();
    check("b2b_wr_waits", 32'(rs_waits[0] + rs_waits[1] + rs_waits[2] + rs_waits[3]), 32'd0);
    add(32'h0, 1'b0, 3'd2, 32'h0);
    add(32'h4, 1'b0, 3'd2, 32'h0);
    add(32'h8, 1'b0, 3'd2, 32'h0);
    add(32'hC, 1'b0, 3'd2, 32'h0);
    run_seq();
    check("b2b_rd_waits", 32'(rs_waits[0] + rs_waits[1] + rs_waits[2] + rs_waits[3]), 32'd0);
    check("b2b_rd0", rs_rdata[0], 32'h01020304);
    check("b2b_rd1", rs_rdata[1], 32'h05060708);
    check("b2b_rd2", rs_rdata[2], 32'h090A0B0C);
    check("b2b_rd3", rs_rdata[3], 32'h0D0E0F10);

    // Reset while the read half of a byte write is in progress.
    begin
      int wr0;
      wr0 = wr_cnt;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h13; hwrite = 1'b1; hsize = 3'd0;
      @(posedge clk); #1;
      rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwdata = 32'h77000000;
      @(negedge clk);
      check("rmw_rst_ram_cen", 32'(ram_cen), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rmw_rst_hreadyout", 32'(hreadyout), 32'd1);
      check("rmw_rst_ram_cen2", 32'(ram_cen), 32'd0);
      @(posedge clk); #1;
      hwdata = 32'h0;
      check("rmw_rst_no_write", 32'(wr_cnt - wr0), 32'd0);
      check("rmw_rst_mem", mem[4], 32'hAA225566);
    end

    // Address aliasing above the RAM size.
    add(32'h00004010, 1'b1, 3'd2, 32'h0BADF00D);
    run_seq();
    check("alias_mem", mem[4], 32'h0BADF00D);

    // IDLE and BUSY with hsel=1: OKAY, zero wait, no RAM access.
    for (int t = 0; t < 2; t++) begin
      hsel = 1'b1; htrans = (t == 0) ? 2'b00 : 2'b01; haddr = 32'h10; hwrite = 1'b0;
      @(negedge clk);
      check("idle_ram_cen", 32'(ram_cen), 32'd0);
      check("idle_hreadyout", 32'(hreadyout), 32'd1);
      check("idle_hresp", 32'(hresp), 32'd0);
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      check("idle_next_hrdata", hrdata, 32'h0);
      check("idle_next_hreadyout", 32'(hreadyout), 32'd1);
      @(posedge clk); #1;
    end

    // Misaligned word write.
    add(32'h12, 1'b1, 3'd2, 32'hCAFEF00D);
    run_seq();
`ifdef AHB_SRAM_ERR_EN
    check("misalign_waits", 32'(rs_waits[0]), 32'd1);
    check("misalign_hresp", 32'(rs_resp[0]), 32'd1);
    check("misalign_mem", mem[4], 32'h0BADF00D);
`else
    check("misalign_waits", 32'(rs_waits[0]), 32'd0);
    check("misalign_hresp", 32'(rs_resp[0]), 32'd0);
    check("misalign_mem", mem[4], 32'hCAFEF00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
